// File: rtl/writeback_unit.sv
// -----------------------------------------------------------------------------
// writeback_unit
//   Write-back stage in front of the 32x32 register file write port. Results
//   from the load (mem) and ALU paths arrive over valid/ready handshakes. They
//   are buffered in an in-order FIFO, and at most one register write is issued
//   per cycle. A scoreboard query reports destination registers that still
//   have writes queued, so decode can stall on them.
//
// Parameters
//   DEPTH  queue entries (power of 2, >= 2)
//   XLEN   data width
//
// Ports
//   clk, rst_n                   rising-edge clock, async active-low reset
//   mem_valid/ready/rd/data      load result handshake (priority producer)
//   alu_valid/ready/rd/data      ALU result handshake
//   rf_reg_write/rf_rd/
//     rf_write_data              registered register-file write port
//   query_rs1/2, busy_rs1/2      scoreboard query / pending-write flags
//   count                        entries currently queued
//
// Configuration
//   WB_BYPASS_EN  when defined, a push into an empty queue loads the rf_*
//                 registers directly (1-cycle latency). It never occupies a
//                 queue slot.
// -----------------------------------------------------------------------------
module writeback_unit #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [XLEN-1:0]  mem_data,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [XLEN-1:0]  alu_data,
  output logic             rf_reg_write,
  output logic [4:0]       rf_rd,
  output logic [XLEN-1:0]  rf_write_data,
  input  logic [4:0]       query_rs1,
  input  logic [4:0]       query_rs2,
  output logic             busy_rs1,
  output logic             busy_rs2,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [4:0]       rd_mem_q   [DEPTH];
  logic [4:0]       rd_mem_d   [DEPTH];
  logic [XLEN-1:0]  data_mem_q [DEPTH];
  logic [XLEN-1:0]  data_mem_d [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_data_q, rf_data_d;

  logic             full;
  logic             mem_fire, alu_fire;
  logic [4:0]       push_rd;
  logic [XLEN-1:0]  push_data;
  logic             push_en;
  logic             pop;
  logic             bypass;
  logic             enq;

  // Handshake and push selection. A full queue refuses both producers even
  // when a pop happens on the same edge.
  always_comb begin
    full      = (count_q == CNT_W'(DEPTH));
    mem_ready = !full;
    alu_ready = !full && !mem_valid;
    mem_fire  = mem_valid && mem_ready;
    alu_fire  = alu_valid && alu_ready;
    push_rd   = mem_fire ? mem_rd   : alu_rd;
    push_data = mem_fire ? mem_data : alu_data;
    // x0 results complete the handshake but are never written.
    push_en   = (mem_fire || alu_fire) && (push_rd != 5'd0);
    pop       = (count_q != '0);
`ifdef WB_BYPASS_EN
    bypass    = push_en && (count_q == '0);
`else
    bypass    = 1'b0;
`endif
    enq       = push_en && !bypass;
  end

  // Queue storage, pointers, count and the registered write port.
  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;

    if (pop) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = rd_mem_q[rptr_q];
      rf_data_d = data_mem_q[rptr_q];
      rptr_d    = rptr_q + 1'b1;
    end else if (bypass) begin
      rf_we_d   = 1'b1;
      rf_rd_d   = push_rd;
      rf_data_d = push_data;
    end

    if (enq) begin
      rd_mem_d[wptr_q]   = push_rd;
      data_mem_d[wptr_q] = push_data;
      wptr_d             = wptr_q + 1'b1;
    end

    case ({enq, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
      rptr_q    <= '0;
      wptr_q    <= '0;
      count_q   <= '0;
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_data_q <= '0;
    end else begin
      rd_mem_q   <= rd_mem_d;
      data_mem_q <= data_mem_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
    end
  end

  // Scoreboard: slot i is live when its distance from the read pointer
  // (modulo DEPTH) is below count. The rf_* stage is deliberately excluded.
  always_comb begin
    logic [PTR_W-1:0] offset;
    busy_rs1 = 1'b0;
    busy_rs2 = 1'b0;
    offset   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rptr_q;
      if (CNT_W'(offset) < count_q) begin
        if ((query_rs1 != 5'd0) && (rd_mem_q[i] == query_rs1)) busy_rs1 = 1'b1;
        if ((query_rs2 != 5'd0) && (rd_mem_q[i] == query_rs2)) busy_rs2 = 1'b1;
      end
    end
  end

  assign rf_reg_write  = rf_we_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_data_q;
  assign count         = count_q;

endmodule
